// File: rtl/step_seq.sv
// Pass sequencer for the systolic step line: walks the pivot/elimination
// schedule phase by phase, spaces passes by GAP idle cycles and guards each pass with a watchdog.
module step_seq #(
  parameter int N       = 4,
  parameter int M       = 3,
  parameter int L       = 8,
  parameter int K       = 16,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1024,
  localparam int CBW = $clog2(K/N+1),
  localparam int RW  = $clog2(L*K/N+2*N+1),
  localparam int PHW = $clog2(L/N+2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic           step_done,
  input  logic           step_fail,
  output logic           step_start,
  output logic [CBW-1:0] step_col_block,
  output logic           step_functionA,
  output logic           step_last_phase,
  output logic [RW-1:0]  step_first_pass_rows,
  output logic [PHW-1:0] phase,
  output logic           busy,
  output logic           host_ok,
  output logic           done,
  output logic           fail,
  output logic           timeout
);

  localparam int P   = (L+N-1)/N;
  localparam int B   = K/N;
  localparam int WDW = $clog2(TIMEOUT+1);
  localparam int GCW = $clog2(GAP+1);
  // Expiry two counts early so the done pulse lands TIMEOUT cycles after step_start.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT-2);
  localparam logic [GCW-1:0] GC_LAST = GCW'((GAP >= 2) ? GAP-2 : 0);

  if (M < 1 || GAP < 1 || TIMEOUT < 2 || (K % N) != 0) begin : g_bad_params
    $error("step_seq: unsupported parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_FIN} state_t;

  state_t         state;
  logic [WDW-1:0] wd;
  logic [GCW-1:0] gcnt;

  int             p_i, cb_i;
  logic [CBW-1:0] nxt_cb;
  logic [PHW-1:0] nxt_ph;
  logic           nxt_f, nxt_last, sched_end;
  logic [RW-1:0]  nxt_rows;
  logic           fail_hit, load_nxt;

  assign p_i  = int'(phase);
  assign cb_i = int'(step_col_block);

  // Next schedule position, derived from the position currently on the outputs.
  always_comb begin
    nxt_cb    = step_col_block;
    nxt_ph    = phase;
    nxt_f     = 1'b0;
    sched_end = 1'b0;
    if (step_functionA && (p_i + 1 < B)) begin
      nxt_cb = CBW'(p_i + 1);
    end else if (!step_functionA && (cb_i + 1 < B)) begin
      nxt_cb = CBW'(cb_i + 1);
    end else if (p_i + 1 < P) begin
      nxt_ph = PHW'(p_i + 1);
      nxt_cb = CBW'(p_i + 1);
      nxt_f  = 1'b1;
    end else begin
      sched_end = 1'b1;
    end
    nxt_last = (int'(nxt_ph) == P-1);
    nxt_rows = nxt_f ? RW'(int'(nxt_cb)*L + N) : '0;
  end

  assign fail_hit = step_done && step_functionA && step_fail;
  // Controls change only on entry to ISSUE, so they hold through the cycle after step_done.
  assign load_nxt = (state == S_GAP && gcnt == GC_LAST) ||
                    (GAP == 1 && state == S_WAIT && step_done && !fail_hit && !sched_end);
  assign host_ok  = ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      step_start           <= 1'b0;
      step_col_block       <= '0;
      step_functionA       <= 1'b0;
      step_last_phase      <= 1'b0;
      step_first_pass_rows <= '0;
      phase                <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      fail                 <= 1'b0;
      timeout              <= 1'b0;
      wd                   <= '0;
      gcnt                 <= '0;
    end else begin
      step_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          fail                 <= 1'b0;
          timeout              <= 1'b0;
          phase                <= '0;
          step_col_block       <= '0;
          step_functionA       <= 1'b1;
          step_last_phase      <= (P == 1);
          step_first_pass_rows <= RW'(N);
          busy                 <= 1'b1;
          state                <= S_ISSUE;
        end
        S_ISSUE: begin
          step_start <= 1'b1;
          wd         <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (step_done) begin
            if (fail_hit) begin
              fail  <= 1'b1;
              state <= S_FIN;
            end else if (sched_end) begin
              state <= S_FIN;
            end else if (GAP == 1) begin
              state <= S_ISSUE;
            end else begin
              gcnt  <= '0;
              state <= S_GAP;
            end
          end else if (wd == WD_LAST) begin
            timeout <= 1'b1;
            state   <= S_FIN;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GC_LAST) state <= S_ISSUE;
          else                 gcnt  <= gcnt + 1'b1;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (load_nxt) begin
        step_col_block       <= nxt_cb;
        step_functionA       <= nxt_f;
        phase                <= nxt_ph;
        step_last_phase      <= nxt_last;
        step_first_pass_rows <= nxt_rows;
      end
    end
  end

endmodule

// File: tb/tb_step_seq.sv
// Randomized bench for step_seq: a step-line responder drives done/fail and the
// observed passes are scored against a schedule built from phase/block loops.
module tb_step_seq;
  localparam int N = 4, L = 8, K = 16, GAP = 2, TO = 64;
  localparam int L2 = 6, K2 = 8;
  localparam int CBW  = $clog2(K/N+1),  RW  = $clog2(L*K/N+2*N+1),   PHW  = $clog2(L/N+2);
  localparam int CBW2 = $clog2(K2/N+1), RW2 = $clog2(L2*K2/N+2*N+1), PHW2 = $clog2(L2/N+2);

  typedef struct {int cb; int f; int last; int rows; int cyc;} rec_t;

  logic clk = 0, rst = 1, go = 0, go_b = 0;
  logic sd = 0, sf = 0, sd_b = 0, sf_b = 0;

  logic           st, fa, lp, bz, hok, dn, fl, tmo;
  logic [CBW-1:0] cb;
  logic [RW-1:0]  rows;
  logic [PHW-1:0] ph;

  logic            st_b, fa_b, lp_b, bz_b, hok_b, dn_b, fl_b, tmo_b;
  logic [CBW2-1:0] cb_b;
  logic [RW2-1:0]  rows_b;
  logic [PHW2-1:0] ph_b;

  step_seq #(.N(N), .M(3), .L(L), .K(K), .GAP(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .go(go), .step_done(sd), .step_fail(sf),
    .step_start(st), .step_col_block(cb), .step_functionA(fa), .step_last_phase(lp),
    .step_first_pass_rows(rows), .phase(ph), .busy(bz), .host_ok(hok),
    .done(dn), .fail(fl), .timeout(tmo));

  step_seq #(.N(N), .M(3), .L(L2), .K(K2), .GAP(GAP), .TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .step_done(sd_b), .step_fail(sf_b),
    .step_start(st_b), .step_col_block(cb_b), .step_functionA(fa_b), .step_last_phase(lp_b),
    .step_first_pass_rows(rows_b), .phase(ph_b), .busy(bz_b), .host_ok(hok_b),
    .done(dn_b), .fail(fl_b), .timeout(tmo_b));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference schedule: each phase pivots on its own block, then eliminates the rest.
  rec_t exp_q[$];
  task automatic build(input int l, input int n, input int k);
    int pn, bn;
    pn = (l+n-1)/n;
    bn = k/n;
    exp_q.delete();
    for (int p = 0; p < pn; p++) begin
      exp_q.push_back('{p, 1, int'(p == pn-1), p*l+n, 0});
      for (int c = p+1; c < bn; c++) exp_q.push_back('{c, 0, int'(p == pn-1), 0, 0});
    end
  endtask

  // Step-line responder for the main instance.
  int dly = 20, fail_at = -1, cd = 0, nst = 0;
  bit rnd_dly = 0, mute = 0, spur = 0, spur_pend = 0;
  int rd_q[$];
  always @(posedge clk) begin
    #2;
    sd = 0; sf = 0;
    if (rst) begin
      cd = 0; spur_pend = 0;
    end else begin
      if (spur_pend) begin sd = 1; spur_pend = 0; end
      if (st) begin
        nst++;
        if (!mute) cd = rnd_dly ? int'($urandom_range(1, 25)) : dly;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sd = 1;
          sf = (nst-1 == fail_at);
          rd_q.push_back(cyc);
          spur_pend = spur;
        end
      end
    end
  end

  int cdb = 0;
  always @(posedge clk) begin
    #2;
    sd_b = 0;
    if (rst) cdb = 0;
    else if (st_b) cdb = 7;
    else if (cdb > 0) begin cdb--; if (cdb == 0) sd_b = 1; end
  end

  rec_t st_q[$], stb_q[$];
  int dn_q[$];
  int ndn_b = 0;
  logic to_at_dn = 0, fl_at_dn = 0;
  always @(negedge clk) begin
    if (st)   st_q.push_back('{int'(cb), int'(fa), int'(lp), int'(rows), cyc});
    if (dn)   begin dn_q.push_back(cyc); to_at_dn = tmo; fl_at_dn = fl; end
    if (st_b) stb_q.push_back('{int'(cb_b), int'(fa_b), int'(lp_b), int'(rows_b), cyc});
    if (dn_b) ndn_b++;
  end

  task automatic clear();
    st_q.delete(); dn_q.delete(); rd_q.delete(); nst = 0;
  endtask

  task automatic pulse_go(output int g);
    @(posedge clk); #1; go = 1; g = cyc;
    @(posedge clk); #1; go = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (dn_q.size() == 0 && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 32'(dn_q.size() != 0), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, st, 0);   chk({tag, "_cb"}, cb, 0);
    chk({tag, "_fa"}, fa, 0);      chk({tag, "_last"}, lp, 0);
    chk({tag, "_rows"}, rows, 0);  chk({tag, "_phase"}, ph, 0);
    chk({tag, "_busy"}, bz, 0);    chk({tag, "_hostok"}, hok, 1);
    chk({tag, "_done"}, dn, 0);    chk({tag, "_fail"}, fl, 0);
    chk({tag, "_tmo"}, tmo, 0);
  endtask

  task automatic check_sched(input string tag, input int g, input int n_exp);
    int n;
    chk({tag, "_nstart"}, st_q.size(), n_exp);
    n = (st_q.size() < n_exp) ? st_q.size() : n_exp;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cb%0d", tag, i),   st_q[i].cb,   exp_q[i].cb);
      chk($sformatf("%s_f%0d", tag, i),    st_q[i].f,    exp_q[i].f);
      chk($sformatf("%s_last%0d", tag, i), st_q[i].last, exp_q[i].last);
      chk($sformatf("%s_rows%0d", tag, i), st_q[i].rows, exp_q[i].rows);
    end
    if (st_q.size() > 0) chk({tag, "_go2start"}, st_q[0].cyc - g, 2);
    for (int i = 1; i < n && i <= rd_q.size(); i++)
      chk($sformatf("%s_gap%0d", tag, i), st_q[i].cyc - rd_q[i-1], GAP+1);
    chk({tag, "_ndone"}, dn_q.size(), 1);
    if (dn_q.size() > 0 && rd_q.size() > 0)
      chk({tag, "_done_lat"}, dn_q[0] - rd_q[rd_q.size()-1], 2);
  endtask

  initial begin
    int g, n, s3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst0");
    @(posedge clk); #1; rst = 0;
    repeat (3) @(posedge clk);

    // Nominal run, fixed 20-cycle step latency.
    build(L, N, K);
    clear(); dly = 20; pulse_go(g);
    @(negedge clk); chk("busy_after_go", bz, 1); chk("hostok_after_go", hok, 0);
    wait_done("nom", 1500);
    check_sched("nom", g, exp_q.size());
    chk("nom_fail", fl, 0); chk("nom_tmo", tmo, 0); chk("nom_busy", bz, 0); chk("nom_hostok", hok, 1);

    // Pivot failure on the phase-1 pivot pass.
    clear(); fail_at = 4; pulse_go(g);
    wait_done("pfail", 1500);
    check_sched("pfail", g, 5);
    chk("pfail_flag_at_done", fl_at_dn, 1);
    chk("pfail_fail", fl, 1); chk("pfail_busy", bz, 0);
    fail_at = -1;
    clear(); pulse_go(g);
    @(negedge clk); chk("go_clears_fail", fl, 0);
    wait_done("refail", 1500);
    check_sched("refail", g, exp_q.size());

    // Step line never answers.
    clear(); mute = 1; pulse_go(g);
    wait_done("wdog", 300);
    if (dn_q.size() > 0 && st_q.size() > 0) chk("wdog_lat", dn_q[0] - st_q[0].cyc, TO);
    chk("wdog_tmo_at_done", to_at_dn, 1);
    repeat (20) @(negedge clk);
    chk("wdog_nstart", st_q.size(), 1); chk("wdog_tmo", tmo, 1);
    chk("wdog_fail", fl, 0); chk("wdog_busy", bz, 0);
    mute = 0;

    // Reset mid-pass, three cycles after the third start.
    clear(); dly = 20; pulse_go(g);
    n = 0;
    while (st_q.size() < 3 && n < 500) begin @(negedge clk); n++; end
    chk("rst_third_start_seen", 32'(st_q.size() >= 3), 1);
    s3 = (st_q.size() >= 3) ? st_q[2].cyc : cyc;
    n = 0;
    while (cyc < s3 + 3 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk_reset("rstmid");
    repeat (5) @(posedge clk);
    clear(); rnd_dly = 1; pulse_go(g);
    wait_done("restart", 1500);
    check_sched("restart", g, exp_q.size());

    // Extra go while busy plus a stray step_done in every gap.
    clear(); spur = 1; pulse_go(g);
    repeat (10) @(posedge clk);
    #1; go = 1; @(posedge clk); #1; go = 0;
    wait_done("spur", 1500);
    check_sched("spur", g, exp_q.size());
    spur = 0;

    // Random latencies; step_fail raised on elimination passes must be ignored.
    for (int r = 0; r < 3; r++) begin
      int pick;
      pick = int'($urandom_range(0, 3));
      fail_at = (pick == 0) ? -1 : ((pick == 1) ? 1 : ((pick == 2) ? 3 : 6));
      clear(); pulse_go(g);
      wait_done($sformatf("rnd%0d", r), 1500);
      check_sched($sformatf("rnd%0d", r), g, exp_q.size());
      chk($sformatf("rnd%0d_fail", r), fl, 0);
    end
    fail_at = -1;

    // Small configuration: L=6, K=8.
    build(L2, N, K2);
    @(posedge clk); #1; go_b = 1; @(posedge clk); #1; go_b = 0;
    n = 0;
    while (ndn_b == 0 && n < 400) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("b_ndone", ndn_b, 1);
    chk("b_nstart", stb_q.size(), exp_q.size());
    for (int i = 0; i < stb_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("b_cb%0d", i),   stb_q[i].cb,   exp_q[i].cb);
      chk($sformatf("b_f%0d", i),    stb_q[i].f,    exp_q[i].f);
      chk($sformatf("b_last%0d", i), stb_q[i].last, exp_q[i].last);
      chk($sformatf("b_rows%0d", i), stb_q[i].rows, exp_q[i].rows);
    end
    chk("b_busy", bz_b, 0); chk("b_fail", fl_b, 0); chk("b_tmo", tmo_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
